// File: rtl/csr_dma_pkg.sv
// csr_dma_pkg -- shared definitions for the CSR-programmed DMA engine.
//
// Contents:
//   state_e       engine FSM states
//   CSR_*         CSR word indices on the slave port (0..7)
//   BUF_BASE      first slave word index of the word buffer
//   CTRL_*        bit positions inside CTRL
//   STAT_*        bit positions inside STATUS
//
// Optional feature: CYCLE_COUNT_EN (used by csr_dma_engine) makes CSR_CYCLES live.

package csr_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_BASE   = 1;
  localparam int CSR_LEN    = 2;
  localparam int CSR_STATUS = 3;
  localparam int CSR_XFER   = 4;
  localparam int CSR_CYCLES = 5;
  localparam int BUF_BASE   = 8;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

endpackage

// File: rtl/csr_dma_buf.sv
// csr_dma_buf -- dual-port word buffer for the DMA engine.
//
// Ports:
//   clk_i         clock
//   slv_we_i      slave-side write enable
//   slv_addr_i    slave-side word index
//   slv_wdata_i   slave-side write data
//   slv_rdata_o   slave-side read data (combinational)
//   eng_we_i      engine-side write enable
//   eng_addr_i    engine-side word index
//   eng_wdata_i   engine-side write data
//   eng_rdata_o   engine-side read data (combinational)
//
// Contents are deliberately not reset. The engine only writes while a
// transfer is active and the top blocks slave writes then, so the two
// write ports never collide; the engine still wins if they ever did.

module csr_dma_buf #(
  parameter int DATAWIDTH = 32,
  parameter int BUF_DEPTH = 16,
  localparam int AW = $clog2(BUF_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 slv_we_i,
  input  logic [AW-1:0]        slv_addr_i,
  input  logic [DATAWIDTH-1:0] slv_wdata_i,
  output logic [DATAWIDTH-1:0] slv_rdata_o,
  input  logic                 eng_we_i,
  input  logic [AW-1:0]        eng_addr_i,
  input  logic [DATAWIDTH-1:0] eng_wdata_i,
  output logic [DATAWIDTH-1:0] eng_rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [BUF_DEPTH];

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (eng_we_i) begin
      mem_q[eng_addr_i] <= eng_wdata_i;
    end else if (slv_we_i) begin
      mem_q[slv_addr_i] <= slv_wdata_i;
    end
  end

  assign slv_rdata_o = mem_q[slv_addr_i];
  assign eng_rdata_o = mem_q[eng_addr_i];

endmodule

// File: rtl/csr_dma_engine.sv
// csr_dma_engine -- slave-programmed DMA between an internal word buffer
// and a memory-mapped master bus.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   slave_address/writedata/write/read/chipselect, slave_readdata
//                                      CSR + buffer access (readdata registered)
//   master_address/writedata/write/read, master_readdata,
//   master_readdatavalid, master_waitrequest
//                                      memory master, one read outstanding
//   busy                               any state other than IDLE
//   irq                                STATUS.done AND CTRL.IRQ_EN
//
// Optional feature macro: CYCLE_COUNT_EN -- CSR 5 becomes a saturating count
// of busy cycles in the most recent transfer; otherwise CSR 5 reads 0.

module csr_dma_engine
  import csr_dma_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32,
  parameter int BUF_DEPTH           = 16,
  parameter int SLAVE_ADDRESSWIDTH  = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           irq
);

  localparam int MAW = MASTER_ADDRESSWIDTH;
  localparam int DW  = DATAWIDTH;
  localparam int SAW = SLAVE_ADDRESSWIDTH;
  localparam int AW  = $clog2(BUF_DEPTH);
  // Word counter must reach BUF_DEPTH itself, hence the +1.
  localparam int CW  = $clog2(BUF_DEPTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [MAW-1:0]  actBase_q, baseCsr_q;
  logic [CW-1:0]   actLen_q;
  logic [DW-1:0]   lenCsr_q;
  logic            dirCsr_q, irqEn_q, done_q, err_q;
  logic [DW-1:0]   rdata_q, readMux;

  logic            csWr, csRd, isCsr, inBuf, goReq, lenOk, startXfer, lastWord;
  logic [2:0]      csrIdx;
  logic [SAW:0]    bufOff;
  logic [MAW-1:0]  wordAddr;
  logic            engWe, slvWe;
  logic [DW-1:0]   slvRdata, engRdata;

  // Slave-side decode: CSR window below BUF_BASE, buffer window above it.
  assign csWr     = slave_chipselect & slave_write;
  assign csRd     = slave_chipselect & slave_read;
  assign isCsr    = slave_address < SAW'(BUF_BASE);
  assign csrIdx   = slave_address[2:0];
  assign bufOff   = {1'b0, slave_address} - (SAW+1)'(BUF_BASE);
  assign inBuf    = !isCsr && (bufOff < (SAW+1)'(BUF_DEPTH));
  assign goReq    = csWr && isCsr && (csrIdx == 3'(CSR_CTRL)) && slave_writedata[CTRL_GO];
  assign lenOk    = (lenCsr_q != '0) && (lenCsr_q <= DW'(BUF_DEPTH));
  assign slvWe    = csWr && inBuf && (state_q == ST_IDLE);
  assign wordAddr = actBase_q + MAW'({idx_q, 2'b00});
  assign lastWord = (idx_q == actLen_q - CW'(1));

  csr_dma_buf #(.DATAWIDTH(DW), .BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk_i       (clk),
    .slv_we_i    (slvWe),
    .slv_addr_i  (bufOff[AW-1:0]),
    .slv_wdata_i (slave_writedata),
    .slv_rdata_o (slvRdata),
    .eng_we_i    (engWe),
    .eng_addr_i  (idx_q[AW-1:0]),
    .eng_wdata_i (master_readdata),
    .eng_rdata_o (engRdata)
  );

  // FSM state and word index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state and master strobes; the strobes decode from state_q so they
  // fall the instant reset is asserted.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    startXfer        = 1'b0;
    engWe            = 1'b0;
    master_write     = 1'b0;
    master_read      = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    case (state_q)
      ST_IDLE: begin
        if (goReq && lenOk) begin
          startXfer = 1'b1;
          idx_d     = '0;
          // Direction comes from the same CTRL write that carries GO.
          state_d   = slave_writedata[CTRL_DIR] ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        master_write     = 1'b1;
        master_address   = wordAddr;
        master_writedata = engRdata;
        if (!master_waitrequest) begin
          idx_d = idx_q + CW'(1);
          if (lastWord) state_d = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        master_read    = 1'b1;
        master_address = wordAddr;
        if (!master_waitrequest) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (master_readdatavalid) begin
          engWe   = 1'b1;
          idx_d   = idx_q + CW'(1);
          state_d = lastWord ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR storage, sticky status with hardware-set priority, registered read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      actBase_q <= '0;
      actLen_q  <= '0;
      baseCsr_q <= '0;
      lenCsr_q  <= '0;
      dirCsr_q  <= 1'b0;
      irqEn_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (startXfer) begin
        actBase_q <= baseCsr_q;
        actLen_q  <= CW'(lenCsr_q);
      end
      if (csWr && isCsr) begin
        case (csrIdx)
          3'(CSR_CTRL): begin
            dirCsr_q <= slave_writedata[CTRL_DIR];
            irqEn_q  <= slave_writedata[CTRL_IRQ_EN];
          end
          3'(CSR_BASE): baseCsr_q <= MAW'(slave_writedata) & ~MAW'(3);
          3'(CSR_LEN):  lenCsr_q  <= slave_writedata;
          default: ;
        endcase
      end
      done_q <= (done_q & ~(csWr && isCsr && (csrIdx == 3'(CSR_STATUS)) && slave_writedata[STAT_DONE]))
                | (state_q == ST_DONE);
      err_q  <= (err_q & ~(csWr && isCsr && (csrIdx == 3'(CSR_STATUS)) && slave_writedata[STAT_ERR]))
                | (goReq & ~startXfer);
      if (csRd) rdata_q <= readMux;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [DW-1:0] cycles_q;

  // Busy-cycle counter for the most recent transfer, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles_q <= '0;
    end else if (startXfer) begin
      cycles_q <= '0;
    end else if ((state_q != ST_IDLE) && (cycles_q != '1)) begin
      cycles_q <= cycles_q + DW'(1);
    end
  end
`endif

  // Slave read mux; unmapped and reserved words read as zero.
  always_comb begin
    readMux = '0;
    if (isCsr) begin
      case (csrIdx)
        3'(CSR_CTRL): begin
          readMux[CTRL_DIR]    = dirCsr_q;
          readMux[CTRL_IRQ_EN] = irqEn_q;
        end
        3'(CSR_BASE): readMux = DW'(baseCsr_q);
        3'(CSR_LEN):  readMux = lenCsr_q;
        3'(CSR_STATUS): begin
          readMux[STAT_BUSY] = (state_q != ST_IDLE);
          readMux[STAT_DONE] = done_q;
          readMux[STAT_ERR]  = err_q;
        end
        3'(CSR_XFER): readMux = DW'(idx_q);
`ifdef CYCLE_COUNT_EN
        3'(CSR_CYCLES): readMux = cycles_q;
`endif
        default: readMux = '0;
      endcase
    end else if (inBuf) begin
      readMux = slvRdata;
    end
  end

  assign slave_readdata = rdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign irq            = done_q & irqEn_q;

endmodule

// File: tb/tb_csr_dma_engine.sv
// tb_csr_dma_engine -- directed bench for csr_dma_engine with a memory
// responder, an expected-write scoreboard and CSR/buffer readback checks.

module tb_csr_dma_engine;

  localparam int MAW = 26;
  localparam int DW  = 32;
  localparam int SAW = 5;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [SAW-1:0] slave_address;
  logic [DW-1:0]  slave_writedata;
  logic           slave_write, slave_read, slave_chipselect;
  logic [DW-1:0]  slave_readdata;
  logic [MAW-1:0] master_address;
  logic [DW-1:0]  master_writedata;
  logic           master_write, master_read;
  logic [DW-1:0]  master_readdata;
  logic           master_readdatavalid, master_waitrequest;
  logic           busy, irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expWrites[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          stallLeft = 0;
  int          strobeCount = 0;
  bit          noResponse = 1'b0;
  bit          pendingRead = 1'b0;
  logic [31:0] readVal = '0;
  logic [31:0] expRdAddr = '0;

  csr_dma_engine dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .slave_address        (slave_address),
    .slave_writedata      (slave_writedata),
    .slave_write          (slave_write),
    .slave_read           (slave_read),
    .slave_chipselect     (slave_chipselect),
    .slave_readdata       (slave_readdata),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .busy                 (busy),
    .irq                  (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: stalls the next stallLeft requests, answers reads one
  // cycle after acceptance, and checks every accepted write against the
  // scoreboard queue.
  initial begin
    wr_t e;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      master_readdatavalid = 1'b0;
      if (pendingRead) begin
        master_readdatavalid = 1'b1;
        master_readdata      = readVal;
        pendingRead          = 1'b0;
      end
      master_waitrequest = 1'b0;
      if (master_write || master_read) begin
        strobeCount++;
        if (stallLeft > 0) begin
          master_waitrequest = 1'b1;
          stallLeft--;
          if (master_read) checkOutput("rd_addr_stall", 32'(master_address), expRdAddr);
        end else if (master_read) begin
          checkOutput("rd_addr", 32'(master_address), expRdAddr);
          if (!noResponse) pendingRead = 1'b1;
        end else if (expWrites.size() == 0) begin
          checkOutput("write_queue_nonempty", 32'(expWrites.size()), 32'd1);
        end else begin
          e = expWrites.pop_front();
          checkOutput("wr_addr", 32'(master_address), e.addr);
          checkOutput("wr_data", master_writedata, e.data);
        end
      end
    end
  end

  task automatic applyStimulus(input int addr, input logic [31:0] data);
    @(negedge clk);
    slave_chipselect = 1'b1;
    slave_write      = 1'b1;
    slave_address    = SAW'(addr);
    slave_writedata  = data;
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_write      = 1'b0;
  endtask

  task automatic checkReg(input string tag, input int addr, input logic [31:0] exp);
    @(negedge clk);
    slave_chipselect = 1'b1;
    slave_read       = 1'b1;
    slave_address    = SAW'(addr);
    @(negedge clk);
    slave_chipselect = 1'b0;
    slave_read       = 1'b0;
    checkOutput(tag, slave_readdata, exp);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic pushWrite(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expWrites.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    slave_address    = '0;
    slave_writedata  = '0;
    slave_write      = 1'b0;
    slave_read       = 1'b0;
    slave_chipselect = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state.
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_mwrite", 32'(master_write), 32'd0);
    checkOutput("rst_mread", 32'(master_read), 32'd0);
    checkOutput("rst_maddr", 32'(master_address), 32'd0);
    checkReg("rst_ctrl", 0, 32'd0);
    checkReg("rst_base", 1, 32'd0);
    checkReg("rst_len", 2, 32'd0);
    checkReg("rst_status", 3, 32'd0);
    checkReg("rst_xfer", 4, 32'd0);

    // Buffer -> memory, four words, with two stalls.
    for (int i = 0; i < 4; i++) applyStimulus(8 + i, 32'(i + 1));
    checkReg("buf9_rb", 9, 32'd2);
    applyStimulus(1, 32'h0080_0000);
    checkReg("base_rb", 1, 32'h0080_0000);
    applyStimulus(2, 32'd4);
    for (int i = 0; i < 4; i++) pushWrite(32'h0080_0000 + 32'(4 * i), 32'(i + 1));
    stallLeft = 2;
    applyStimulus(0, 32'h1);
    waitIdle("wr4_idle");
    checkOutput("wr4_queue_empty", 32'(expWrites.size()), 32'd0);
    checkReg("wr4_status", 3, 32'h2);
    checkReg("wr4_xfer", 4, 32'd4);
    applyStimulus(3, 32'h6);
    checkReg("w1c_status", 3, 32'h0);

    // Memory -> buffer, one word, three-cycle stall.
    readVal   = 32'hA5A5_A5A5;
    expRdAddr = 32'h100;
    applyStimulus(1, 32'h100);
    applyStimulus(2, 32'd1);
    stallLeft = 3;
    applyStimulus(0, 32'h3);
    waitIdle("rd1_idle");
    checkReg("rd1_buf0", 8, 32'hA5A5_A5A5);
    checkReg("rd1_status", 3, 32'h2);
    checkReg("rd1_xfer", 4, 32'd1);
    applyStimulus(3, 32'h6);

    // Illegal lengths.
    strobeCount = 0;
    applyStimulus(2, 32'd0);
    applyStimulus(0, 32'h1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    checkReg("len0_status", 3, 32'h4);
    applyStimulus(3, 32'h6);
    applyStimulus(2, 32'd17);
    applyStimulus(0, 32'h1);
    checkOutput("len17_busy", 32'(busy), 32'd0);
    checkReg("len17_status", 3, 32'h4);
    checkOutput("badlen_strobes", 32'(strobeCount), 32'd0);
    applyStimulus(3, 32'h6);

    // Address wrap-around.
    applyStimulus(8, 32'h11);
    applyStimulus(9, 32'h22);
    applyStimulus(1, 32'h03FF_FFFC);
    checkReg("wrap_base_rb", 1, 32'h03FF_FFFC);
    applyStimulus(2, 32'd2);
    pushWrite(32'h03FF_FFFC, 32'h11);
    pushWrite(32'h0000_0000, 32'h22);
    applyStimulus(0, 32'h1);
    waitIdle("wrap_idle");
    checkOutput("wrap_queue_empty", 32'(expWrites.size()), 32'd0);
    checkReg("wrap_status", 3, 32'h2);
    applyStimulus(3, 32'h6);

    // BASE low bits are forced to zero.
    applyStimulus(1, 32'h123);
    checkReg("base_align", 1, 32'h120);

    // GO and buffer write while busy must not disturb the transfer.
    for (int i = 0; i < 4; i++) applyStimulus(8 + i, 32'h100 + 32'(i));
    applyStimulus(1, 32'h200);
    applyStimulus(2, 32'd4);
    for (int i = 0; i < 4; i++) pushWrite(32'h200 + 32'(4 * i), 32'h100 + 32'(i));
    stallLeft = 10;
    applyStimulus(0, 32'h1);
    applyStimulus(2, 32'd1);
    applyStimulus(8, 32'hDEAD_BEEF);
    applyStimulus(0, 32'h1);
    waitIdle("busygo_idle");
    checkOutput("busygo_queue_empty", 32'(expWrites.size()), 32'd0);
    checkReg("busygo_status", 3, 32'h6);
    checkReg("busygo_xfer", 4, 32'd4);
    checkReg("busygo_buf0", 8, 32'h100);
    applyStimulus(3, 32'h6);

    // Interrupt and its write-1-to-clear.
    applyStimulus(1, 32'h0);
    applyStimulus(2, 32'd1);
    pushWrite(32'h0, 32'h100);
    applyStimulus(0, 32'h5);
    waitIdle("irq_idle");
    checkOutput("irq_set", 32'(irq), 32'd1);
    checkReg("irq_ctrl_rb", 0, 32'h4);
    applyStimulus(3, 32'h2);
    checkOutput("irq_cleared", 32'(irq), 32'd0);

    // Reset while waiting for read data.
    noResponse = 1'b1;
    expRdAddr  = 32'h40;
    applyStimulus(1, 32'h40);
    applyStimulus(0, 32'h3);
    @(negedge clk);
    checkOutput("rdwait_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_mread", 32'(master_read), 32'd0);
    checkOutput("midrst_mwrite", 32'(master_write), 32'd0);
    checkOutput("midrst_irq", 32'(irq), 32'd0);
    checkOutput("midrst_rdata", slave_readdata, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    noResponse = 1'b0;
    checkReg("midrst_status", 3, 32'h0);
    checkReg("midrst_ctrl", 0, 32'h0);

    // Reserved and unmapped words.
    applyStimulus(30, 32'h1234_5678);
    checkReg("unmapped_rd", 30, 32'h0);
    checkReg("reserved6", 6, 32'h0);
`ifndef CYCLE_COUNT_EN
    checkReg("reserved5", 5, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
